// File: rtl/dmux8_arb_pkg.sv
// Shared types and constants for the 8-way round-robin dmux arbiter.
package dmux8_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [SEL_W-1:0] req_idx_t;

    function automatic logic [NUM_REQ-1:0] onehot(input req_idx_t idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request scanning from last+1 with wrap.
module rr_pick8
    import dmux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output logic               valid,
    output req_idx_t           win
);

    req_idx_t               start;
    req_idx_t               rot_idx;
    logic [2*NUM_REQ-1:0]   dbl;
    logic [NUM_REQ-1:0]     rot;

    assign start = last + req_idx_t'(1);

    always_comb begin
        dbl     = {req, req};
        // rot[0] is the request right after the previous owner
        rot     = dbl[start +: NUM_REQ];
        rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = req_idx_t'(i);
            end
        end
        valid = |req;
        win   = rot_idx + start;
    end

endmodule

// File: rtl/dmux8_rr_arbiter.sv
// Round-robin arbiter for one dmux_8_way path; grant held until release.
// Optional grant timeout enabled by defining DMUX8_ARB_TIMEOUT_EN.
module dmux8_rr_arbiter
    import dmux8_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               timeout
);

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    req_idx_t           sel_q;
    req_idx_t           last_q;
    logic               pick_valid;
    req_idx_t           pick_win;

    rr_pick8 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .win   (pick_win)
    );

`ifdef DMUX8_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;
`else
    logic [31:0] unused_max_hold;
    assign unused_max_hold = 32'(MAX_HOLD);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= req_idx_t'(NUM_REQ - 1);
`ifdef DMUX8_ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef DMUX8_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= onehot(pick_win);
                        sel_q   <= pick_win;
                        state_q <= GRANT;
`ifdef DMUX8_ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    // sel_q holds the current owner for the whole grant
                    if (done || !req[sel_q]) begin
                        gnt_q   <= '0;
                        last_q  <= sel_q;
                        state_q <= IDLE;
`ifdef DMUX8_ARB_TIMEOUT_EN
                    end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                        gnt_q     <= '0;
                        last_q    <= sel_q;
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
`endif
                    end
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = |gnt_q;
`ifdef DMUX8_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dmux8_rr_arbiter.sv
// Self-checking bench for dmux8_rr_arbiter with a cycle-level reference model.
module tb_dmux8_rr_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 when idle), previous owner, visible select.
    int m_owner;
    int m_last;
    int m_sel;
    int m_held;
    bit m_tmo;
`ifdef DMUX8_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    dmux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        if (reset) begin
            m_owner = -1;
            m_last  = 7;
            m_sel   = 0;
            m_held  = 0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= 8; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % 8]) begin
                        m_owner = (m_last + k) % 8;
                    end
                end
                if (m_owner >= 0) begin
                    m_sel  = m_owner;
                    m_held = 1;
                end
            end else if (done || !req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (TMO_EN && m_held == MAX_HOLD) begin
                m_last  = m_owner;
                m_owner = -1;
                m_tmo   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step();
        logic [7:0] exp_gnt;
        @(posedge clk);
        model_edge();
        #1;
        exp_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        n_checks++;
        if (gnt !== exp_gnt) begin
            n_fail++;
            $display("FAIL model_gnt: got %h expected %h at %0t", gnt, exp_gnt, $time);
        end
        n_checks++;
        if (sel !== 3'(m_sel)) begin
            n_fail++;
            $display("FAIL model_sel: got %0d expected %0d at %0t", sel, m_sel, $time);
        end
        n_checks++;
        if (timeout !== m_tmo) begin
            n_fail++;
            $display("FAIL model_timeout: got %b expected %b at %0t", timeout, m_tmo, $time);
        end
        n_checks++;
        if ($onehot0(gnt) !== 1'b1) begin
            n_fail++;
            $display("FAIL onehot0: gnt=%h at %0t", gnt, $time);
        end
        n_checks++;
        if (busy !== (|gnt)) begin
            n_fail++;
            $display("FAIL busy_eq_or_gnt: busy=%b gnt=%h at %0t", busy, gnt, $time);
        end
        if (gnt != 8'h00) begin
            n_checks++;
            if (gnt !== (8'h01 << sel)) begin
                n_fail++;
                $display("FAIL sel_matches_gnt: sel=%0d gnt=%h at %0t", sel, gnt, $time);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic expect_gnt(input string name, input logic [7:0] exp);
        n_checks++;
        if (gnt !== exp) begin
            n_fail++;
            $display("FAIL %s: gnt got %h expected %h", name, gnt, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        expect_gnt("reset_gnt", 8'h00);
        n_checks++;
        if (sel !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: sel=%0d busy=%b timeout=%b expected 0 0 0",
                     sel, busy, timeout);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h01;
        step();
        expect_gnt("single_grant", 8'h01);
        done = 1'b1;
        step();
        expect_gnt("single_release", 8'h00);
        n_checks++;
        if (sel !== 3'd0) begin
            n_fail++;
            $display("FAIL single_sel_hold: sel got %0d expected 0", sel);
        end
        done = 1'b0;
        req  = 8'h00;
        step();
    endtask

    task automatic test_fairness();
        do_reset();
        req = 8'hFF;
        step();
        for (int i = 0; i <= 8; i++) begin
            expect_gnt($sformatf("fair_grant_%0d", i), 8'h01 << (i % 8));
            done = 1'b1;
            step();
            done = 1'b0;
            expect_gnt($sformatf("fair_bubble_%0d", i), 8'h00);
            step();
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 8'h08;
        step();
        expect_gnt("owner3_grant", 8'h08);
        req = 8'h28;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_gnt("owner3_no_preempt", 8'h08);
        end
        req = 8'h20;
        step();
        expect_gnt("owner3_release", 8'h00);
        step();
        expect_gnt("owner5_after_bubble", 8'h20);
        req = 8'h00;
        step();
    endtask

    task automatic test_rerequest();
        do_reset();
        req = 8'h0A;
        step();
        expect_gnt("rr_first", 8'h02);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        expect_gnt("rr_other_first", 8'h08);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h08;
        step();
        expect_gnt("rr_only_requester", 8'h08);
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h04;
        step();
        expect_gnt("mid_owner2", 8'h04);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_gnt("mid_reset_gnt", 8'h00);
        n_checks++;
        if (busy !== 1'b0 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy=%b sel=%0d expected 0 0", busy, sel);
        end
        step();
        expect_gnt("mid_regrant", 8'h04);
        req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h10;
`ifdef DMUX8_ARB_TIMEOUT_EN
        for (int i = 0; i < MAX_HOLD; i++) begin
            step();
            expect_gnt("tmo_held", 8'h10);
        end
        step();
        expect_gnt("tmo_drop", 8'h00);
        n_checks++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_pulse: timeout got %b expected 1", timeout);
        end
        step();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse_width: timeout got %b expected 0", timeout);
        end
        expect_gnt("tmo_regrant", 8'h10);
        for (int i = 1; i < MAX_HOLD; i++) begin
            step();
        end
        done = 1'b1;
        step();
        done = 1'b0;
        expect_gnt("tmo_done_at_limit", 8'h00);
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_done_wins: timeout got %b expected 0", timeout);
        end
`else
        step();
        for (int i = 0; i < 100; i++) begin
            step();
            expect_gnt("hold_forever", 8'h10);
            n_checks++;
            if (timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_no_timeout: timeout got %b expected 0", timeout);
            end
        end
`endif
        req = 8'h00;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 8'($urandom);
            end
            done  = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        done  = 1'b0;
        req   = 8'h00;
        step();
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_no_preempt();
        test_rerequest();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
